// File: rtl/scroll_message_display.sv
// Scrolling message display: a small character buffer shown on a row of
// 7-segment digits, rotated one slot per TICK_DIV enabled clock cycles.
module scroll_message_display #(
   parameter int NUM_DIGITS = 5,
   parameter int MSG_LEN    = 8,
   parameter int TICK_DIV   = 50000000
) (
   input  logic                    Clock,
   input  logic                    Reset,
   input  logic                    Enable,
   input  logic                    Dir,
   input  logic                    Clear,
   input  logic                    Wr_en,
   input  logic [5:0]              Wr_addr,
   input  logic [2:0]              Wr_data,
   output logic [7*NUM_DIGITS-1:0] HEX,
   output logic [5:0]              Offset,
   output logic                    Step
);

   localparam int            CW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
   localparam logic [5:0]    OFF_MAX = 6'(MSG_LEN - 1);

   function automatic logic [2:0] init_char(input int slot);
      case (slot)
         0:       return 3'b000;
         1:       return 3'b001;
         2:       return 3'b011;
         3:       return 3'b011;
         4:       return 3'b010;
         default: return 3'b111;
      endcase
   endfunction

   function automatic logic [6:0] seg_decode(input logic [2:0] c);
      case (c)
         3'b000:  return 7'b0001001;
         3'b001:  return 7'b0000110;
         3'b011:  return 7'b1000111;
         3'b010:  return 7'b1000000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [3*MSG_LEN-1:0] msg_reset_image();
      logic [3*MSG_LEN-1:0] m;
      m = '1;
      for (int i = 0; i < MSG_LEN; i++) m[3*i +: 3] = init_char(i);
      return m;
   endfunction

   // Reset image is the decode of the reset buffer at offset 0.
   function automatic logic [7*NUM_DIGITS-1:0] hex_reset_image();
      logic [7*NUM_DIGITS-1:0] img;
      img = '1;
      for (int k = 0; k < NUM_DIGITS; k++)
         img[7*k +: 7] = seg_decode(init_char(NUM_DIGITS - 1 - k));
      return img;
   endfunction

   localparam logic [3*MSG_LEN-1:0]    MSG_RESET = msg_reset_image();
   localparam logic [7*NUM_DIGITS-1:0] HEX_RESET = hex_reset_image();

   logic [CW-1:0]           cnt;
   logic [5:0]              offset_r;
   logic [5:0]              offset_next;
   logic [3*MSG_LEN-1:0]    msg;
   logic [7*NUM_DIGITS-1:0] hex_r;
   logic [7*NUM_DIGITS-1:0] hex_next;
   logic [6:0]              slot_sum;
   logic [2:0]              ch;
   logic                    step_now;

   assign step_now = Enable && !Clear && !Reset && (cnt == CNT_MAX);

   always_comb begin
      offset_next = offset_r;
      if (step_now) begin
         if (!Dir) offset_next = (offset_r == OFF_MAX) ? 6'd0 : offset_r + 6'd1;
         else      offset_next = (offset_r == 6'd0) ? OFF_MAX : offset_r - 6'd1;
      end
   end

   // Clear outranks Enable, so a pending step is dropped in a clear cycle.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         cnt      <= '0;
         offset_r <= '0;
      end else if (Clear) begin
         cnt      <= '0;
         offset_r <= '0;
      end else if (Enable) begin
         cnt      <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
         offset_r <= offset_next;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         msg <= MSG_RESET;
      end else begin
         for (int i = 0; i < MSG_LEN; i++)
            if (Wr_en && (Wr_addr == 6'(i))) msg[3*i +: 3] <= Wr_data;
      end
   end

   // Offset and the digit index are both below MSG_LEN, so one subtraction wraps.
   always_comb begin
      hex_next = '1;
      slot_sum = '0;
      ch       = 3'b111;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         slot_sum = 7'(offset_r) + 7'(NUM_DIGITS - 1 - k);
         if (slot_sum >= 7'(MSG_LEN)) slot_sum = slot_sum - 7'(MSG_LEN);
         ch = 3'b111;
         for (int s = 0; s < MSG_LEN; s++)
            if (slot_sum == 7'(s)) ch = msg[3*s +: 3];
         hex_next[7*k +: 7] = seg_decode(ch);
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) hex_r <= HEX_RESET;
      else       hex_r <= hex_next;
   end

   assign HEX    = hex_r;
   assign Offset = offset_r;
   assign Step   = step_now;

endmodule

// File: tb/tb_scroll_message_display.sv
// Bench for scroll_message_display: random and directed scrolling traffic
// compared cycle by cycle against a slot/offset model through an expected queue.
module tb_scroll_message_display;

   localparam int ND = 5;
   localparam int ML = 8;
   localparam int TD = 4;
   localparam int W  = 7*ND + 6 + 1;

   localparam logic [34:0] HELLO = {7'b0001001, 7'b0000110, 7'b1000111, 7'b1000111, 7'b1000000};
   localparam logic [34:0] BHELL = {7'b1111111, 7'b0001001, 7'b0000110, 7'b1000111, 7'b1000111};

   logic          Clock = 1'b0;
   logic          Reset, Enable, Dir, Clear, Wr_en;
   logic [5:0]    Wr_addr;
   logic [2:0]    Wr_data;
   logic [7*ND-1:0] HEX;
   logic [5:0]    Offset;
   logic          Step;

   scroll_message_display #(.NUM_DIGITS(ND), .MSG_LEN(ML), .TICK_DIV(TD)) dut (
      .Clock(Clock), .Reset(Reset), .Enable(Enable), .Dir(Dir), .Clear(Clear),
      .Wr_en(Wr_en), .Wr_addr(Wr_addr), .Wr_data(Wr_data),
      .HEX(HEX), .Offset(Offset), .Step(Step)
   );

   // clock / reset
   always #5 Clock = ~Clock;

   int n_tests = 0;
   int n_fail  = 0;
   logic [W-1:0] exp_q[$];

   // reference model: message slots, offset, tick count, displayed image
   int          m_off, m_cnt;
   int          m_buf[ML];
   logic [34:0] m_hex;
   bit          p_en, p_dir, p_clr, p_we, p_rst;
   int          p_wa, p_wd;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg_of(input int c);
      case (c)
         0:       return 7'b0001001;
         1:       return 7'b0000110;
         3:       return 7'b1000111;
         2:       return 7'b1000000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [34:0] image_of();
      logic [34:0] img;
      for (int k = 0; k < ND; k++) img[7*k +: 7] = seg_of(m_buf[(m_off + ND - 1 - k) % ML]);
      return img;
   endfunction

   task automatic model_reset();
      int init_tab[5] = '{0, 1, 3, 3, 2};
      m_off = 0;
      m_cnt = 0;
      for (int i = 0; i < ML; i++) m_buf[i] = (i < 5) ? init_tab[i] : 7;
      m_hex = image_of();
   endtask

   // One rising edge with the inputs held during the cycle just ended.
   task automatic model_edge();
      logic [34:0] new_hex;
      if (p_rst) begin
         model_reset();
      end else begin
         new_hex = image_of();
         if (p_clr) begin
            m_cnt = 0;
            m_off = 0;
         end else if (p_en) begin
            if (m_cnt == TD - 1) m_off = p_dir ? (m_off + ML - 1) % ML : (m_off + 1) % ML;
            m_cnt = (m_cnt + 1) % TD;
         end
         if (p_we && p_wa < ML) m_buf[p_wa] = p_wd;
         m_hex = new_hex;
      end
   endtask

   // driver: one clock cycle of stimulus, expected outputs pushed for the monitor
   task automatic cyc(input bit en, input bit dir, input bit clr, input bit we,
                      input int wa, input int wd, input bit rst);
      bit exp_step;
      @(posedge Clock);
      #1;
      model_edge();
      Enable = en; Dir = dir; Clear = clr; Wr_en = we;
      Wr_addr = 6'(wa); Wr_data = 3'(wd); Reset = rst;
      if (rst) model_reset();
      exp_step = en && !clr && !rst && (m_cnt == TD - 1);
      exp_q.push_back({m_hex, 6'(m_off), exp_step});
      if (rst && !p_rst) begin
         #1;
         check("async_reset_hex", 64'(HEX), 64'(HELLO));
         check("async_reset_offset", 64'(Offset), 64'd0);
      end
      p_en = en; p_dir = dir; p_clr = clr; p_we = we; p_wa = wa; p_wd = wd; p_rst = rst;
   endtask

   // monitor: compares mid-cycle, away from the active edge
   always @(negedge Clock) begin
      logic [W-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("hex", 64'(HEX), 64'(e[W-1:7]));
         check("offset", 64'(Offset), 64'(e[6:1]));
         check("step", 64'(Step), 64'(e[0]));
      end
   end

   initial begin
      Reset = 1'b1; Enable = 1'b0; Dir = 1'b0; Clear = 1'b0; Wr_en = 1'b0;
      Wr_addr = '0; Wr_data = '0;
      p_rst = 1'b1; p_en = 0; p_dir = 0; p_clr = 0; p_we = 0; p_wa = 0; p_wd = 0;
      model_reset();

      // reset, then idle with Enable low
      repeat (3) cyc(0, 0, 0, 0, 0, 0, 1);
      repeat (10) cyc(0, 0, 0, 0, 0, 0, 0);
      check("idle_hello", 64'(HEX), 64'(HELLO));
      check("idle_offset", 64'(Offset), 64'd0);

      // right scroll from offset 0 wraps to MSG_LEN-1
      repeat (5) cyc(1, 1, 0, 0, 0, 0, 0);
      check("right_wrap_offset", 64'(Offset), 64'd7);
      cyc(1, 1, 0, 0, 0, 0, 0);
      check("right_wrap_hex", 64'(HEX), 64'(BHELL));

      // left scroll through a full wrap
      repeat (40) cyc(1, 0, 0, 0, 0, 0, 0);

      // clear in a step cycle at offset 3
      for (int i = 0; i < 64 && !(m_off == 3 && m_cnt == 2); i++) cyc(1, 0, 0, 0, 0, 0, 0);
      check("reach_clear_point", 64'(m_off == 3 && m_cnt == 2), 64'd1);
      cyc(1, 0, 1, 0, 0, 0, 0);
      repeat (6) cyc(1, 0, 0, 0, 0, 0, 0);

      // write slot 5 in a step cycle, then an out-of-range write
      for (int i = 0; i < 8 && m_cnt != 2; i++) cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 1, 5, 0, 0);
      cyc(1, 0, 0, 1, 9, 1, 0);
      repeat (12) cyc(1, 0, 0, 0, 0, 0, 0);

      // randomized traffic
      for (int i = 0; i < 500; i++)
         cyc($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 12), $urandom_range(0, 7),
             $urandom_range(0, 99) == 0);

      // reset mid-scroll at offset 6 after writes
      cyc(1, 0, 0, 1, 0, 6, 0);
      cyc(1, 0, 0, 1, 2, 7, 0);
      for (int i = 0; i < 64 && !(m_off == 6 && m_cnt == 1); i++) cyc(1, 0, 0, 0, 0, 0, 0);
      check("reach_reset_point", 64'(m_off == 6 && m_cnt == 1), 64'd1);
      cyc(1, 0, 0, 1, 3, 0, 1);
      cyc(1, 0, 0, 0, 0, 0, 0);
      repeat (10) cyc(1, 0, 0, 0, 0, 0, 0);

      @(negedge Clock);
      #1;
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/scroll_message_display.md
SCROLL_MESSAGE_DISPLAY -- requirements
Module: scroll_message_display

Interface
REQ-001 Parameter NUM_DIGITS, default 5: number of 7-segment digits driven.
REQ-002 Parameter MSG_LEN, default 8: number of 3-bit character slots in the message buffer; legal range NUM_DIGITS <= MSG_LEN <= 64.
REQ-003 Parameter TICK_DIV, default 50000000: clock cycles per scroll step; legal range TICK_DIV >= 1.
REQ-004 Port Clock, input, 1: single clock; every register is rising-edge triggered.
REQ-005 Port Reset, input, 1: reset, asynchronous and active-high.
REQ-006 Port Enable, input, 1: 1 = scrolling runs; 0 = tick counter and offset hold.
REQ-007 Port Dir, input, 1: 0 = scroll left (offset increments); 1 = scroll right (offset decrements).
REQ-008 Port Clear, input, 1: synchronous restart of tick counter and offset.
REQ-009 Port Wr_en, input, 1: message buffer write strobe.
REQ-010 Port Wr_addr, input, 6: message slot to write.
REQ-011 Port Wr_data, input, 3: character code to write.
REQ-012 Port HEX, output, 7*NUM_DIGITS: active-low segments; bits [7k+6:7k] drive digit k; digit 0 is rightmost.
REQ-013 Port Offset, output, 6: current scroll offset, zero-extended.
REQ-014 Port Step, output, 1: one-cycle pulse in the cycle the offset changes.

Function
REQ-015 Character codes SHALL decode as: 000 -> 'H' (0001001), 001 -> 'E' (0000110), 011 -> 'L' (1000111), 010 -> 'O' (1000000), all others -> blank (1111111).
REQ-016 Digit k SHALL show message slot (Offset + NUM_DIGITS-1-k) mod MSG_LEN, so the leftmost digit shows slot Offset.
REQ-017 HEX SHALL be registered: it reflects buffer contents and Offset as of the previous clock edge (1-cycle latency).
REQ-018 Tick counter SHALL count 0..TICK_DIV-1 while Enable=1 and Clear=0, wrapping to 0.
REQ-019 In the cycle the counter is at TICK_DIV-1 with Enable=1, Step SHALL be 1.
- Offset SHALL update on that edge: Dir=0 -> (Offset+1) mod MSG_LEN; Dir=1 -> (Offset+MSG_LEN-1) mod MSG_LEN.
REQ-020 Wrap-around: Offset SHALL go MSG_LEN-1 -> 0 when scrolling left and 0 -> MSG_LEN-1 when scrolling right.
REQ-021 While Enable=0, the counter, Offset and HEX (for an unchanged buffer) SHALL hold, and Step SHALL be 0.
REQ-022 Clear=1 SHALL zero the counter and Offset on the next edge, force Step=0, and take priority over Enable and a pending step.
REQ-023 Wr_en=1 with Wr_addr < MSG_LEN SHALL write Wr_data into that slot on the edge; writes with Wr_addr >= MSG_LEN SHALL be ignored.
REQ-024 A write and a step in the same cycle SHALL both take effect; the next HEX value reflects both.
REQ-025 Writes SHALL be accepted regardless of Enable and Clear.
REQ-026 A change of Dir SHALL affect only steps that occur after the change; it SHALL NOT reset the counter.
REQ-027 Offset width SHALL be 6 bits internally; Offset < MSG_LEN SHALL hold at all times.

Reset
REQ-028 Reset=1 SHALL immediately set counter=0, Offset=0 and Step=0.
REQ-029 Reset=1 SHALL load buffer slots 0..4 = H,E,L,L,O (000,001,011,011,010) and all remaining slots = 111 (blank).
REQ-030 Reset=1 SHALL set HEX to the decoded reset image; for NUM_DIGITS=5 this is HEX4..HEX0 = H,E,L,L,O.
REQ-031 Reset asserted mid-operation SHALL abort any step in progress and discard no-longer-valid writes; the first step after release occurs TICK_DIV cycles after the first enabled edge.

Verification (NUM_DIGITS=5, MSG_LEN=8, TICK_DIV=4)
REQ-032 Reset, Enable=0 for 10 cycles -> HEX4..0 = 0001001, 0000110, 1000111, 1000111, 1000000; Offset=0; Step never 1.
REQ-033 Enable=1, Dir=0 -> Step pulses every 4th cycle; Offset sequence 1,2,...,7,0; after the first step HEX4..0 = E,L,L,O,blank.
REQ-034 Dir=1 from Offset=0 -> next step gives Offset=7; HEX4..0 = blank,H,E,L,L.
REQ-035 Wr_en with Wr_addr=5, Wr_data=000 in the same cycle as a step -> both applied; 2 steps later slot 5 appears on the correct digit as H; Wr_addr=9 -> no change.
REQ-036 Clear at Offset=3 in a step cycle -> Offset=0, Step=0, counter restarts; next Step 4 cycles later.
REQ-037 Reset pulse mid-scroll at Offset=6 after buffer writes -> Offset=0 and HEX restored to HELLO in the same cycle, without waiting for a clock edge.
